// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cacheSystem port among N_REQ requesters, one transaction in flight.
// Optional macro ARB_LATENCY_CNT_EN builds the latency counter behind lat_cycles (tied to zero otherwise).
module cache_req_arbiter #(
    parameter int  N_REQ  = 4,
    parameter int  ADDR_W = 16,
    parameter int  DATA_W = 32,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_done,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [ADDR_W-1:0]         cache_addr,
    output logic                      cache_enable,
    output logic                      cache_write,
    output logic [DATA_W-1:0]         cache_dataIn,
    input  logic                      cache_requestComplete,
    input  logic [DATA_W-1:0]         cache_dataOut,
    output logic [15:0]               lat_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_id_q, grant_id_d;
    logic [N_REQ-1:0]    req_done_q, req_done_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   cache_addr_q, cache_addr_d;
    logic                cache_enable_q, cache_enable_d;
    logic                cache_write_q, cache_write_d;
    logic [DATA_W-1:0]   cache_data_in_q, cache_data_in_d;

    logic                pick_found_s;
    logic [ID_W-1:0]     pick_id_s;
    logic [ID_W-1:0]     scan_id_s;
    logic [ID_W-1:0]     next_ptr_s;

`ifdef ARB_LATENCY_CNT_EN
    logic [15:0]         lat_cnt_q, lat_cnt_d;
    logic [15:0]         lat_cycles_q, lat_cycles_d;
    logic [15:0]         lat_inc_s;
`endif

    // Round-robin pick: scan downward so the candidate closest after rr_ptr is written last and wins.
    always_comb begin
        pick_found_s = |req_valid;
        pick_id_s    = '0;
        scan_id_s    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_id_s = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            pick_id_s = req_valid[scan_id_s] ? scan_id_s : pick_id_s;
        end
        next_ptr_s = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
    end

    // Next-state logic for the handshake sequencer and all registered outputs.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        req_done_d      = '0;
        rsp_data_d      = rsp_data_q;
        cache_addr_d    = cache_addr_q;
        cache_enable_d  = cache_enable_q;
        cache_write_d   = cache_write_q;
        cache_data_in_d = cache_data_in_q;
`ifdef ARB_LATENCY_CNT_EN
        lat_inc_s       = (lat_cnt_q == 16'hFFFF) ? 16'hFFFF : lat_cnt_q + 16'd1;
        lat_cnt_d       = lat_cnt_q;
        lat_cycles_d    = lat_cycles_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_id_d      = pick_id_s;
                    cache_addr_d    = req_addr[int'(pick_id_s) * ADDR_W +: ADDR_W];
                    cache_write_d   = req_write[pick_id_s];
                    cache_data_in_d = req_data[int'(pick_id_s) * DATA_W +: DATA_W];
                    cache_enable_d  = 1'b1;
                    state_d         = ST_ISSUE;
`ifdef ARB_LATENCY_CNT_EN
                    lat_cnt_d       = 16'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
`ifdef ARB_LATENCY_CNT_EN
                lat_cnt_d = lat_inc_s;
`endif
                if (cache_requestComplete) begin
                    cache_enable_d = 1'b0;
                    rsp_data_d     = cache_dataOut;
                    req_done_d     = N_REQ'(1) << grant_id_q;
                    rr_ptr_d       = next_ptr_s;
                    state_d        = ST_RELEASE;
`ifdef ARB_LATENCY_CNT_EN
                    lat_cycles_d   = lat_inc_s;
`endif
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RELEASE: begin
                cache_enable_d = 1'b0;
                state_d        = ST_IDLE;
            end
            default: begin
                cache_enable_d = 1'b0;
                state_d        = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            grant_id_q      <= '0;
            req_done_q      <= '0;
            rsp_data_q      <= '0;
            busy_q          <= 1'b0;
            cache_addr_q    <= '0;
            cache_enable_q  <= 1'b0;
            cache_write_q   <= 1'b0;
            cache_data_in_q <= '0;
`ifdef ARB_LATENCY_CNT_EN
            lat_cnt_q       <= 16'd0;
            lat_cycles_q    <= 16'd0;
`endif
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_id_q      <= grant_id_d;
            req_done_q      <= req_done_d;
            rsp_data_q      <= rsp_data_d;
            busy_q          <= busy_d;
            cache_addr_q    <= cache_addr_d;
            cache_enable_q  <= cache_enable_d;
            cache_write_q   <= cache_write_d;
            cache_data_in_q <= cache_data_in_d;
`ifdef ARB_LATENCY_CNT_EN
            lat_cnt_q       <= lat_cnt_d;
            lat_cycles_q    <= lat_cycles_d;
`endif
        end
    end

    assign req_done     = req_done_q;
    assign rsp_data     = rsp_data_q;
    assign grant_id     = grant_id_q;
    assign busy         = busy_q;
    assign cache_addr   = cache_addr_q;
    assign cache_enable = cache_enable_q;
    assign cache_write  = cache_write_q;
    assign cache_dataIn = cache_data_in_q;
`ifdef ARB_LATENCY_CNT_EN
    assign lat_cycles   = lat_cycles_q;
`else
    assign lat_cycles   = 16'd0;
`endif

endmodule
